// File: rtl/fir_mac_nch.sv
// fir_mac_nch: N-channel FIR filter with one time-multiplexed MAC per channel.
//
// Every channel keeps its own circular sample history. All channels share one
// coefficient set, read from an external ROM with a one-cycle read latency.
// Results are rounded (round half up), then saturated to DW bits.
//
// Ports
//   clk       : clock, everything changes on the rising edge
//   rst       : synchronous active-high reset; it restarts the history clear
//   in_vld    : input sample vector valid
//   in_rdy    : block can accept a sample vector (high only in IDLE)
//   smp_in    : NCH signed samples; channel k is at [k*DW +: DW]
//   coef_addr : coefficient ROM address (the current tap index)
//   coef      : ROM data, valid one cycle after coef_addr
//   out_vld   : one-cycle pulse, out/sat hold a new result
//   out       : NCH filtered samples, packed like smp_in; held between pulses
//   sat       : per-channel saturation flag for the current out
//   dbg_state : current FSM state (CLR=0, IDLE=1, MAC=2, DONE=3)
//
// Handshake: a vector transfers on a rising edge where in_vld && in_rdy.
// The source holds in_vld and smp_in stable until that edge. in_vld while
// in_rdy is low is ignored. out_vld is a pulse with no back-pressure.
module fir_mac_nch #(
    parameter int NCH    = 2,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int NTAPS  = 1021,
    parameter int AW     = $clog2(NTAPS),
    parameter int ACCW   = DW + CW + AW,
    parameter int OSHIFT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [NCH*DW-1:0] smp_in,
    output logic [AW-1:0]     coef_addr,
    input  logic [CW-1:0]     coef,
    output logic              out_vld,
    output logic [NCH*DW-1:0] out,
    output logic [NCH-1:0]    sat,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_CLR  = 2'd0,
        S_IDLE = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [AW-1:0]        LAST_IDX = AW'(NTAPS - 1);
    localparam logic [AW:0]          NTAPS_E  = (AW + 1)'(NTAPS);
    localparam logic signed [ACCW-1:0] RND_C  = ACCW'(2 ** (OSHIFT - 1));
    localparam logic signed [ACCW-1:0] OMAX   = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] OMIN   = -OMAX - ACCW'(1);

    state_e                  state_q;
    logic [AW-1:0]           clr_cnt_q;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           k_q;
    logic                    drain_q;
    logic                    mac_vld_q;
    logic                    in_rdy_q;
    logic                    out_vld_q;
    logic [NCH*DW-1:0]       out_q;
    logic [NCH-1:0]          sat_q;
    logic signed [ACCW-1:0]  acc_q     [NCH];
    logic signed [DW-1:0]    hist_q    [NCH][NTAPS];
    logic signed [DW-1:0]    hist_rd_q [NCH];

    logic                    accept_d;
    logic [AW-1:0]           hist_idx_d;
    logic signed [DW+CW-1:0] prod_d    [NCH];
    logic signed [ACCW-1:0]  rnd_d     [NCH];
    logic [NCH*DW-1:0]       out_d;
    logic [NCH-1:0]          sat_d;

    assign accept_d  = in_vld && in_rdy_q;
    assign in_rdy    = in_rdy_q;
    assign out_vld   = out_vld_q;
    assign out       = out_q;
    assign sat       = sat_q;
    assign coef_addr = k_q;
    assign dbg_state = state_q;

    // Tap k reads the sample written k vectors ago: (wr_ptr - k) mod NTAPS.
    always_comb begin
        hist_idx_d = '0;
        if (k_q > wr_ptr_q) begin
            hist_idx_d = AW'({1'b0, wr_ptr_q} + NTAPS_E - {1'b0, k_q});
        end else begin
            hist_idx_d = wr_ptr_q - k_q;
        end
    end

    // The history read is registered so that it lines up with the ROM data
    // for the same tap one cycle later.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            hist_rd_q[c] <= hist_q[c][hist_idx_d];
            if (!rst) begin
                if (state_q == S_CLR) begin
                    hist_q[c][clr_cnt_q] <= '0;
                end else if (accept_d) begin
                    hist_q[c][wr_ptr_q] <= smp_in[c*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        out_d = '0;
        sat_d = '0;
        for (int c = 0; c < NCH; c++) begin
            prod_d[c] = $signed(coef) * hist_rd_q[c];
            rnd_d[c]  = (acc_q[c] + RND_C) >>> OSHIFT;
            if (rnd_d[c] > OMAX) begin
                out_d[c*DW +: DW] = OMAX[DW-1:0];
                sat_d[c]          = 1'b1;
            end else if (rnd_d[c] < OMIN) begin
                out_d[c*DW +: DW] = OMIN[DW-1:0];
                sat_d[c]          = 1'b1;
            end else begin
                out_d[c*DW +: DW] = rnd_d[c][DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLR;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            drain_q   <= 1'b0;
            mac_vld_q <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            sat_q     <= '0;
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
        end else begin
            out_vld_q <= 1'b0;
            mac_vld_q <= 1'b0;
            // mac_vld_q marks that coef and hist_rd_q hold the operands of the
            // tap issued in the previous cycle.
            if (mac_vld_q) begin
                for (int c = 0; c < NCH; c++) acc_q[c] <= acc_q[c] + ACCW'(prod_d[c]);
            end
            case (state_q)
                S_CLR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        clr_cnt_q <= '0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (in_vld) begin
                        in_rdy_q <= 1'b0;
                        k_q      <= '0;
                        drain_q  <= 1'b0;
                        for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
                        state_q  <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (!drain_q) begin
                        mac_vld_q <= 1'b1;
                        if (k_q == LAST_IDX) begin
                            drain_q <= 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else begin
                        // Extra cycle: the last product is accumulated above.
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_q     <= out_d;
                    sat_q     <= sat_d;
                    out_vld_q <= 1'b1;
                    wr_ptr_q  <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
                    k_q       <= '0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_nch.sv
// Bench for fir_mac_nch with a 5-tap, 2-channel configuration.
module tb_fir_mac_nch;

  localparam int NCH = 2;
  localparam int DW = 16;
  localparam int NTAPS = 5;
  localparam int AW = 3;
  localparam int W = NCH * DW + NCH;
  localparam time PERIOD = 10;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic in_vld;
  logic in_rdy;
  logic [NCH*DW-1:0] smp_in;
  logic [AW-1:0] coef_addr;
  logic [15:0] coef;
  logic out_vld;
  logic [NCH*DW-1:0] out;
  logic [NCH-1:0] sat;
  logic [1:0] dbg_state;

  fir_mac_nch #(
    .NCH(NCH), .DW(DW), .CW(16), .NTAPS(NTAPS), .AW(AW), .ACCW(16 + 16 + AW), .OSHIFT(15)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .smp_in(smp_in),
    .coef_addr(coef_addr), .coef(coef), .out_vld(out_vld), .out(out), .sat(sat),
    .dbg_state(dbg_state)
  );

  // registered coefficient ROM
  logic [15:0] rom [NTAPS];
  always @(posedge clk) coef <= (int'(coef_addr) < NTAPS) ? rom[coef_addr] : 16'h0000;

  // scoreboard
  logic [W-1:0] exp_q[$];
  time exp_t_q[$];
  int n_tests = 0;
  int n_fail = 0;
  string cur_test = "reset";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    time te;
    forever begin
      @(negedge clk);
      if (out_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s/unexpected_out_vld: got out=%0h sat=%0h expected no pulse", cur_test, out, sat);
        end else begin
          e = exp_q.pop_front();
          te = exp_t_q.pop_front();
          chk("out_sat", 64'({sat, out}), 64'(e));
          chk("latency_time", 64'($time), 64'(te));
        end
      end
    end
  end

  // golden model: newest sample first
  int mdl_h0 [NTAPS];
  int mdl_h1 [NTAPS];

  function automatic void mdl_clear();
    for (int i = 0; i < NTAPS; i++) begin
      mdl_h0[i] = 0;
      mdl_h1[i] = 0;
    end
  endfunction

  function automatic logic [DW:0] mdl_filter(input int h [NTAPS]);
    longint acc;
    longint r;
    logic [15:0] c;
    acc = 0;
    for (int k = 0; k < NTAPS; k++) begin
      c = rom[k];
      acc += longint'($signed(c)) * longint'(h[k]);
    end
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic logic [W-1:0] mdl_step(input logic [15:0] s0, input logic [15:0] s1);
    logic [DW:0] r0;
    logic [DW:0] r1;
    for (int i = NTAPS - 1; i > 0; i--) begin
      mdl_h0[i] = mdl_h0[i-1];
      mdl_h1[i] = mdl_h1[i-1];
    end
    mdl_h0[0] = int'($signed(s0));
    mdl_h1[0] = int'($signed(s1));
    r0 = mdl_filter(mdl_h0);
    r1 = mdl_filter(mdl_h1);
    return {r1[DW], r0[DW], r1[DW-1:0], r0[DW-1:0]};
  endfunction

  // driver tasks (called and returning at a falling edge)
  task automatic send(input logic [15:0] s0, input logic [15:0] s1, input bit want, input logic [W-1:0] e);
    int cnt;
    smp_in = {s1, s0};
    in_vld = 1'b1;
    cnt = 0;
    while (in_rdy !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (in_rdy !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/in_rdy_timeout: got in_rdy=%b expected 1 within 100 cycles", cur_test, in_rdy);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    if (want) begin
      exp_q.push_back(e);
      exp_t_q.push_back($time + (NTAPS + 2) * PERIOD + PERIOD / 2);
    end
    #1 in_vld = 1'b0;
    @(negedge clk);
    chk("rdy_low_in_mac", 64'(in_rdy), 64'(0));
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1;
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'(0));
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_sat", 64'(sat), 64'(0));
    chk("rst_coef_addr", 64'(coef_addr), 64'(0));
    mdl_clear();
    rst = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (in_rdy !== 1'b1 && cnt < 50);
    chk("clr_cycles", 64'(cnt), 64'(NTAPS));
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // impulse with coef[k]=k+1: ch0 +0x4000, ch1 -0x4000, then zeros
  task automatic impulse_seq();
    int e0 [6] = '{1, 1, 2, 2, 3, 0};
    int e1 [6] = '{0, -1, -1, -2, -2, 0};
    logic [15:0] a;
    logic [15:0] b;
    for (int k = 0; k < NTAPS; k++) rom[k] = 16'(k + 1);
    for (int i = 0; i < 6; i++) begin
      a = 16'(e0[i]);
      b = 16'(e1[i]);
      send((i == 0) ? 16'h4000 : 16'h0000, (i == 0) ? 16'hC000 : 16'h0000, 1'b1, {2'b00, b, a});
    end
    wait_drain();
  endtask

  logic [15:0] t5_tab [15] = '{16'h7FFF, 16'h1234, 16'h8000, 16'h0000, 16'h4000,
                               16'hC000, 16'h7FFF, 16'h7FFF, 16'h0001, 16'hFFFF,
                               16'h5555, 16'hAAAA, 16'h8000, 16'h8000, 16'h0F0F};

  initial begin
    int cnt;
    logic [15:0] s0;
    logic [15:0] s1;
    rst = 1'b1;
    in_vld = 1'b0;
    smp_in = '0;
    for (int k = 0; k < NTAPS; k++) rom[k] = 16'h0000;
    @(negedge clk);

    // 1: reset and clear sequence, no output activity
    cur_test = "reset";
    do_reset();
    repeat (10) @(negedge clk);
    chk("idle_out", 64'(out), 64'(0));

    // 2: impulse response and latency
    cur_test = "impulse";
    impulse_seq();
    repeat (4) @(negedge clk);
    chk("out_hold", 64'(out), 64'(32'h0000_0000));

    // 3: saturation in both directions
    cur_test = "saturation";
    do_reset();
    for (int k = 0; k < NTAPS; k++) rom[k] = 16'h7FFF;
    send(16'h7FFF, 16'h8000, 1'b1, {2'b00, 16'h8001, 16'h7FFE});
    send(16'h7FFF, 16'h8000, 1'b1, {2'b11, 16'h8000, 16'h7FFF});
    send(16'h7FFF, 16'h8000, 1'b1, {2'b11, 16'h8000, 16'h7FFF});
    wait_drain();

    // 4: rounding on a single non-zero tap
    cur_test = "rounding";
    for (int k = 0; k < NTAPS; k++) rom[k] = (k == 0) ? 16'h0001 : 16'h0000;
    send(16'h4000, 16'h3FFF, 1'b1, {2'b00, 16'h0000, 16'h0001});
    send(16'hC000, 16'hBFFF, 1'b1, {2'b00, 16'hFFFF, 16'h0000});
    send(16'h7FFF, 16'h8000, 1'b1, {2'b00, 16'hFFFF, 16'h0001});
    wait_drain();

    // 5: history wrap against the model
    cur_test = "wrap";
    do_reset();
    rom[0] = 16'h2000;
    rom[1] = 16'hF000;
    rom[2] = 16'h0800;
    rom[3] = 16'h7FFF;
    rom[4] = 16'h8000;
    for (int i = 0; i < 2 * NTAPS + 5; i++) begin
      s0 = t5_tab[i];
      s1 = t5_tab[i] ^ 16'h5A5A;
      send(s0, s1, 1'b1, mdl_step(s0, s1));
    end
    wait_drain();

    // 6: reset in the middle of MAC, then a clean impulse
    cur_test = "reset_mid_mac";
    send(16'h7FFF, 16'h7FFF, 1'b0, '0);
    cnt = 0;
    while (coef_addr !== AW'(NTAPS / 2) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("reached_mid_tap", 64'(coef_addr), 64'(NTAPS / 2));
    do_reset();
    impulse_seq();

    repeat (NTAPS + 10) @(negedge clk);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(exp_t_q.pop_front());
      n_tests++;
      n_fail++;
      $display("FAIL end/missing_out_vld: got no pulse expected one more result");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
